// File: rtl/zx_kbd_matrix_ctrl.sv
// zx_kbd_matrix_ctrl
//   Turns the PS/2 set-2 scancode byte stream from the UART receiver into the
//   ZX Spectrum 8x5 keyboard matrix. It tracks make and break codes, and it
//   answers ULA port-0xFE reads with active-low column data.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset; clears all state
//   rx_data    scancode byte
//   rx_valid   single-cycle byte strobe; every byte is accepted
//   kbd_clear  synchronous request to release all keys and restart parsing
//   addr_hi    CPU A[15:8]; a 0 bit selects that half-row
//   kbd_cols   registered active-low column data of the selected half-rows
//   any_key    registered, high while any matrix key is pressed
//
// Build option
//   ZX_KBD_COMPOUND_EN  adds compound keys that press CAPS together with a
//                       second key: Backspace and the four arrow keys.

module zx_kbd_matrix_ctrl #(
    parameter int SEQ_TIMEOUT = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       kbd_clear,
    input  logic [7:0] addr_hi,
    output logic [4:0] kbd_cols,
    output logic       any_key
);

    localparam int TMO_W = $clog2(SEQ_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(SEQ_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;

    state_t           state, state_next;
    logic [2:0]       skip_cnt, skip_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic [39:0]      keys;
    logic [39:0]      matrix;
    logic             do_make, do_brk, do_clear, ext_sel;
    logic [6:0]       lk;

    // Returns {hit, bit index}; the bit index is row*5 + column.
    function automatic logic [6:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [6:0] r;
        r = 7'd0;
        if (ext) begin
            case (code)
                8'h14:   r = {1'b1, 6'd36};
                8'h5A:   r = {1'b1, 6'd30};
                default: r = 7'd0;
            endcase
        end else begin
            case (code)
                8'h12, 8'h59: r = {1'b1, 6'd0};
                8'h1A: r = {1'b1, 6'd1};   8'h22: r = {1'b1, 6'd2};
                8'h21: r = {1'b1, 6'd3};   8'h2A: r = {1'b1, 6'd4};
                8'h1C: r = {1'b1, 6'd5};   8'h1B: r = {1'b1, 6'd6};
                8'h23: r = {1'b1, 6'd7};   8'h2B: r = {1'b1, 6'd8};
                8'h34: r = {1'b1, 6'd9};   8'h15: r = {1'b1, 6'd10};
                8'h1D: r = {1'b1, 6'd11};  8'h24: r = {1'b1, 6'd12};
                8'h2D: r = {1'b1, 6'd13};  8'h2C: r = {1'b1, 6'd14};
                8'h16: r = {1'b1, 6'd15};  8'h1E: r = {1'b1, 6'd16};
                8'h26: r = {1'b1, 6'd17};  8'h25: r = {1'b1, 6'd18};
                8'h2E: r = {1'b1, 6'd19};  8'h45: r = {1'b1, 6'd20};
                8'h46: r = {1'b1, 6'd21};  8'h3E: r = {1'b1, 6'd22};
                8'h3D: r = {1'b1, 6'd23};  8'h36: r = {1'b1, 6'd24};
                8'h4D: r = {1'b1, 6'd25};  8'h44: r = {1'b1, 6'd26};
                8'h43: r = {1'b1, 6'd27};  8'h3C: r = {1'b1, 6'd28};
                8'h35: r = {1'b1, 6'd29};  8'h5A: r = {1'b1, 6'd30};
                8'h4B: r = {1'b1, 6'd31};  8'h42: r = {1'b1, 6'd32};
                8'h3B: r = {1'b1, 6'd33};  8'h33: r = {1'b1, 6'd34};
                8'h29: r = {1'b1, 6'd35};  8'h14: r = {1'b1, 6'd36};
                8'h3A: r = {1'b1, 6'd37};  8'h31: r = {1'b1, 6'd38};
                8'h32: r = {1'b1, 6'd39};
                default: r = 7'd0;
            endcase
        end
        return r;
    endfunction

    // Parser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            skip_cnt <= 3'd0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_next;
            skip_cnt <= skip_next;
            tmo_cnt  <= tmo_next;
        end
    end

    // Parser next state and byte classification; kbd_clear beats rx_valid
    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        tmo_next   = '0;
        do_make    = 1'b0;
        do_brk     = 1'b0;
        do_clear   = 1'b0;
        ext_sel    = (state == EXT) || (state == EXT_BRK);
        if (kbd_clear) begin
            do_clear   = 1'b1;
            state_next = IDLE;
            skip_next  = 3'd0;
        end else if (rx_valid) begin
            if (rx_data == 8'h00 || rx_data == 8'hAA || rx_data == 8'hFF) begin
                do_clear   = 1'b1;
                state_next = IDLE;
                skip_next  = 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_data == 8'hF0) state_next = BRK;
                        else if (rx_data == 8'hE0) state_next = EXT;
                        else if (rx_data == 8'hE1) begin
                            state_next = SKIP;
                            skip_next  = 3'd7;
                        end else do_make = 1'b1;
                    end
                    BRK: begin
                        do_brk     = 1'b1;
                        state_next = IDLE;
                    end
                    EXT: begin
                        if (rx_data == 8'hF0) state_next = EXT_BRK;
                        else begin
                            do_make    = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    EXT_BRK: begin
                        do_brk     = 1'b1;
                        state_next = IDLE;
                    end
                    SKIP: begin
                        skip_next = skip_cnt - 3'd1;
                        if (skip_cnt <= 3'd1) state_next = IDLE;
                    end
                    default: state_next = IDLE;
                endcase
            end
        end else if (state != IDLE) begin
            // Abandon a stalled prefix sequence after SEQ_TIMEOUT quiet cycles.
            if (tmo_cnt >= TMO_LAST) begin
                state_next = IDLE;
                skip_next  = 3'd0;
            end else begin
                tmo_next = tmo_cnt + 1'b1;
            end
        end
    end

    assign lk = key_lookup(rx_data, ext_sel);

    // Direct key matrix; repeated makes and stray breaks are harmless
    always_ff @(posedge clk) begin
        if (rst || do_clear) keys <= '0;
        else if (lk[6] && do_make) keys[lk[5:0]] <= 1'b1;
        else if (lk[6] && do_brk) keys[lk[5:0]] <= 1'b0;
    end

`ifdef ZX_KBD_COMPOUND_EN
    logic [4:0] comp;
    logic [4:0] comp_hit;

    // One-hot compound key: bit0 Backspace, bit1 left, bit2 down, bit3 up, bit4 right
    always_comb begin
        comp_hit = 5'd0;
        if (!ext_sel) begin
            if (rx_data == 8'h66) comp_hit = 5'b00001;
        end else begin
            case (rx_data)
                8'h6B:   comp_hit = 5'b00010;
                8'h72:   comp_hit = 5'b00100;
                8'h75:   comp_hit = 5'b01000;
                8'h74:   comp_hit = 5'b10000;
                default: comp_hit = 5'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || do_clear) comp <= 5'd0;
        else if (do_make) comp <= comp | comp_hit;
        else if (do_brk) comp <= comp & ~comp_hit;
    end

    // Compound keys are ORed over the direct matrix so a held Shift survives
    // the release of a compound key.
    always_comb begin
        matrix     = keys;
        matrix[0]  = keys[0] | (|comp);
        matrix[20] = keys[20] | comp[0];
        matrix[19] = keys[19] | comp[1];
        matrix[24] = keys[24] | comp[2];
        matrix[23] = keys[23] | comp[3];
        matrix[22] = keys[22] | comp[4];
    end
`else
    assign matrix = keys;
`endif

    logic [4:0] sel;

    always_comb begin
        sel = 5'd0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) sel = sel | matrix[r*5 +: 5];
        end
    end

    // Registered read path
    always_ff @(posedge clk) begin
        if (rst) begin
            kbd_cols <= 5'h1F;
            any_key  <= 1'b0;
        end else begin
            kbd_cols <= ~sel;
            any_key  <= |matrix;
        end
    end

endmodule

// File: tb/tb_zx_kbd_matrix_ctrl.sv
module tb_zx_kbd_matrix_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       kbd_clear;
    logic [7:0] addr_hi;
    logic [4:0] kbd_cols;
    logic       any_key;

    int checks = 0;
    int errors = 0;

    zx_kbd_matrix_ctrl #(.SEQ_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .kbd_clear(kbd_clear), .addr_hi(addr_hi), .kbd_cols(kbd_cols),
        .any_key(any_key)
    );

    always #5 clk = ~clk;

    // Called at a negedge; byte is taken at the next posedge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic chk_cols(input logic [4:0] exp, input string tag);
        checks++;
        assert (kbd_cols === exp) else begin
            errors++;
            $error("FAIL %s kbd_cols observed %h expected %h", tag, kbd_cols, exp);
        end
    endtask

    task automatic chk_any(input logic exp, input string tag);
        checks++;
        assert (any_key === exp) else begin
            errors++;
            $error("FAIL %s any_key observed %b expected %b", tag, any_key, exp);
        end
    endtask

    task automatic look(input logic [7:0] a, input logic [4:0] exp, input string tag);
        addr_hi = a;
        @(negedge clk);
        chk_cols(exp, tag);
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; kbd_clear = 1'b0; addr_hi = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_cols(5'h1F, "reset_cols");
        chk_any(1'b0, "reset_any");
        look(8'hFE, 5'h1F, "reset_row_a8");
        chk_any(1'b0, "reset_any2");

        send(8'h1C); send(8'h15);
        look(8'hFB, 5'h1E, "q_make");
        send(8'hF0); send(8'h15);
        look(8'hFB, 5'h1F, "q_break");
        look(8'hFD, 5'h1E, "a_held");
        chk_any(1'b1, "a_any");

        send(8'h1B);
        look(8'hFD, 5'h1C, "a_s_both");
        send(8'hF0); send(8'h1B);

        send(8'hE0); send(8'h14);
        look(8'h7F, 5'h1D, "ext_sym_make");
        send(8'hE0); send(8'hF0); send(8'h14);
        look(8'h7F, 5'h1F, "ext_sym_break");

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1A);
        look(8'hFE, 5'h1D, "pause_then_z");
        look(8'h7F, 5'h1F, "pause_no_sym");
        look(8'hFD, 5'h1E, "pause_a_kept");
        send(8'hF0); send(8'h1A);

        // Break still honoured just before the timeout expires: releases A.
        send(8'hF0);
        repeat (T - 1) @(negedge clk);
        send(8'h1C);
        look(8'hFD, 5'h1F, "brk_before_tmo");

        send(8'hF0);
        repeat (T + 1) @(negedge clk);
        send(8'h22);
        look(8'hFE, 5'h1B, "tmo_make_x");

        send(8'h22); send(8'hF0); send(8'h22); send(8'hF0); send(8'h22);
        look(8'hFE, 5'h1F, "dup_make_break");

        send(8'hE0); send(8'h15);
        look(8'hFB, 5'h1F, "ext_unmapped");
        send(8'h15);
        look(8'hFB, 5'h1E, "after_unmapped");
        send(8'hF0); send(8'h15);

        send(8'h1C); send(8'h12); send(8'h16);
        look(8'h00, 5'h1E, "held_three");
        chk_any(1'b1, "held_any");
        send(8'hAA);
        look(8'h00, 5'h1F, "aa_clear");
        chk_any(1'b0, "aa_any");

        send(8'h1B);
        rx_data = 8'h1C; rx_valid = 1'b1; kbd_clear = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; kbd_clear = 1'b0;
        look(8'hFD, 5'h1F, "kbd_clear_wins");

        send(8'hF0);
        kbd_clear = 1'b1;
        @(negedge clk);
        kbd_clear = 1'b0;
        send(8'h1C);
        look(8'hFD, 5'h1E, "kbd_clear_idle");
        send(8'hF0); send(8'h1C);

        send(8'hF0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_cols(5'h1F, "mid_reset_cols");
        send(8'h1C);
        look(8'hFD, 5'h1E, "rst_mid_make");
        send(8'hF0); send(8'h1C);

        send(8'h5A);
        look(8'hBF, 5'h1E, "enter_make");
        send(8'hE0); send(8'hF0); send(8'h5A);
        look(8'hBF, 5'h1F, "enter_ext_break");

`ifdef ZX_KBD_COMPOUND_EN
        send(8'h12); send(8'h66);
        look(8'hEE, 5'h1E, "bksp_overlap");
        send(8'hF0); send(8'h66);
        look(8'hFE, 5'h1E, "shift_kept");
        look(8'hEF, 5'h1F, "zero_released");
        send(8'hE0); send(8'h6B);
        look(8'hF7, 5'h0F, "left_caps5");
        send(8'hF0); send(8'h12);
        look(8'hFE, 5'h1E, "caps_by_left");
        send(8'hE0); send(8'hF0); send(8'h6B);
        look(8'hF6, 5'h1F, "left_released");
        chk_any(1'b0, "compound_any");
`else
        send(8'h66);
        look(8'hEF, 5'h1F, "bksp_unmapped");
        send(8'hE0); send(8'h6B);
        look(8'hF6, 5'h1F, "left_unmapped");
        chk_any(1'b0, "unmapped_any");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zx_kbd_matrix_ctrl.md
# zx_kbd_matrix_ctrl

- Converts the PS/2 set-2 scancode byte stream from the UART receiver into the ZX Spectrum 8×5 keyboard matrix.
- Answers ULA port-0xFE keyboard reads with active-low column data for the half-rows selected by the address high byte.
- Sits between the UART RX byte interface and the ULA I/O read path; it replaces toggle-style key tracking with real make/break tracking.

## Interface

Parameters:
- SEQ_TIMEOUT, default 270000: idle cycles (10 ms at 27 MHz) after which an incomplete prefix sequence is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: one clock, synchronous, active-high. All state is cleared on the rising edge of clk while rst=1.
- rx_data  in  8  scancode byte.
- rx_valid  in  1  single-cycle strobe; every byte is accepted, there is no ready signal.
- kbd_clear  in  1  synchronous request to release all keys.
- addr_hi  in  8  CPU A[15:8] during a port-0xFE read; a 0 bit selects that half-row.
- kbd_cols  out  5  active-low column data; bit n is key n of each selected half-row.
- any_key  out  1  high while any matrix key is pressed.

## Operation

Matrix rows, keys listed bit0→bit4:
- A8: CAPS, Z, X, C, V
- A9: A, S, D, F, G
- A10: Q, W, E, R, T
- A11: 1, 2, 3, 4, 5
- A12: 0, 9, 8, 7, 6
- A13: P, O, I, U, Y
- A14: ENTER, L, K, J, H
- A15: SPACE, SYM, M, N, B

Plain code map:
- Letters and digits use standard set-2 codes, e.g. Q=15, A=1C, Z=1A, 1=16, 0=45, P=4D, N=31.
- 12 and 59 (L/R shift) → CAPS. 14 → SYM. 29 → SPACE. 5A → ENTER.

Extended (E0-prefixed) map:
- E0 14 → SYM. E0 5A → ENTER.
- Every other extended code is unmapped unless added under Configuration.

Parser FSM, states IDLE, BRK, EXT, EXT_BRK, SKIP:
- IDLE: F0→BRK; E0→EXT; E1→SKIP with skip counter=7; any other byte is a make code (set the key) and the FSM stays in IDLE.
- BRK: the next byte is a break code (clear the key) → IDLE.
- EXT: F0→EXT_BRK; any other byte is an extended make → IDLE.
- EXT_BRK: the next byte is an extended break → IDLE.
- SKIP: each byte decrements the counter; the FSM goes to IDLE when the counter reaches 0. This swallows the Pause sequence.
- Clear codes 00, AA, FF in any state: release all keys and go to IDLE.
- Unmapped codes: consumed with no matrix change; the FSM still advances.
- Make of a key already pressed and break of a key already released are no-ops.
- Timeout: in any state other than IDLE, if no rx_valid arrives for SEQ_TIMEOUT cycles, go to IDLE. The idle counter restarts on every accepted byte.
- kbd_clear: releases all keys and forces IDLE. If it coincides with rx_valid, the clear wins and the byte is dropped.

Read path:
- kbd_cols = ~(bitwise OR of the row vectors r for which addr_hi[r]=0).
- addr_hi=FF gives 1F.
- any_key = OR of all 40 matrix bits.

## Timing

- Reset values: kbd_cols=5'h1F, any_key=0, all keys released, FSM in IDLE, counters 0.
- A byte takes effect on the matrix at the clock edge where it is accepted.
- kbd_cols and any_key are registered. They reflect the addr_hi and matrix values from the previous clock, so latency is 1 cycle.
- Bytes may arrive on consecutive cycles; every state processes one byte per cycle.
- If rst is asserted mid-sequence (e.g. right after F0), the next byte after reset is treated as a make code.

## Configuration

ZX_KBD_COMPOUND_EN: enables compound keys that press CAPS together with a second key.

With the macro defined:
- 66 (Backspace) → CAPS+0.
- E0 6B → CAPS+5. E0 72 → CAPS+6. E0 75 → CAPS+7. E0 74 → CAPS+8.
- Compound keys are tracked in a separate 5-bit register. CAPS reads as pressed if the direct shift key is held or any compound key is held, so releasing Backspace while Shift is held keeps CAPS pressed. Digit keys are ORed the same way.
- Clear codes and kbd_clear also clear the compound register.

Without the macro:
- 66 and the arrow codes are unmapped; the compound register is absent.

## Test plan

- Reset, then addr_hi=FE → kbd_cols=1F one cycle later, any_key=0.
- Bytes 1C, then 15, addr_hi=FB → kbd_cols=1E. Then F0 15 → kbd_cols=1F. addr_hi=FD → kbd_cols=1E (A still held), any_key=1.
- E0 14, addr_hi=7F → kbd_cols=1D. E0 F0 14 → 1F. E1 14 77 E1 F0 14 F0 77, then 1A with addr_hi=FE → kbd_cols=1D (Z pressed; the Pause bytes caused no change).
- F0, idle SEQ_TIMEOUT+1 cycles, then 22 → X pressed (treated as a make code); addr_hi=FE → kbd_cols=1B.
- Hold 1C, 12, 16. Send AA → all released, kbd_cols=1F. Separately, kbd_clear coinciding with rx_valid=1, rx_data=1C → A not pressed.
- With ZX_KBD_COMPOUND_EN: 12, then 66, addr_hi=EE → kbd_cols=1E (CAPS and 0 overlap on bit0). F0 66, addr_hi=FE → 1E (shift still held). addr_hi=EF → 1F.
